// File: rtl/identificador_compuerta_pkg.sv
// Shared constants for the 2-input gate characteriser: FSM states,
// classification codes and the reference truth tables they decode from.
package identificador_compuerta_pkg;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        ESPERAR    = 2'd1,
        CLASIFICAR = 2'd2
    } estado_t;

    localparam logic [2:0] TIPO_OTRA = 3'd0;
    localparam logic [2:0] TIPO_AND  = 3'd1;
    localparam logic [2:0] TIPO_NAND = 3'd2;
    localparam logic [2:0] TIPO_OR   = 3'd3;
    localparam logic [2:0] TIPO_NOR  = 3'd4;
    localparam logic [2:0] TIPO_XOR  = 3'd5;
    localparam logic [2:0] TIPO_XNOR = 3'd6;

    // Truth tables indexed by the input combination: bit i = output for inputs == i.
    localparam logic [3:0] TABLA_AND  = 4'b1000;
    localparam logic [3:0] TABLA_NAND = 4'b0111;
    localparam logic [3:0] TABLA_OR   = 4'b1110;
    localparam logic [3:0] TABLA_NOR  = 4'b0001;
    localparam logic [3:0] TABLA_XOR  = 4'b0110;
    localparam logic [3:0] TABLA_XNOR = 4'b1001;

endpackage

// File: rtl/identificador_compuerta_clasificador_tabla.sv
// Combinational truth-table classifier; shared with other lab checkers,
// so it stays free of any clocking or handshake.
module clasificador_tabla
    import identificador_compuerta_pkg::*;
(
    input  logic [3:0] TablaVerdad,
    output logic [2:0] Tipo
);

    always_comb begin
        case (TablaVerdad)
            TABLA_AND:  Tipo = TIPO_AND;
            TABLA_NAND: Tipo = TIPO_NAND;
            TABLA_OR:   Tipo = TIPO_OR;
            TABLA_NOR:  Tipo = TIPO_NOR;
            TABLA_XOR:  Tipo = TIPO_XOR;
            TABLA_XNOR: Tipo = TIPO_XNOR;
            // NOTE: the default arm assigns Tipo on every path, so no latch is inferred.
            default:    Tipo = TIPO_OTRA;
        endcase
    end

endmodule

// File: rtl/identificador_compuerta.sv
// Gate characteriser: steps a 2-input gate through all four input
// combinations, samples each result after ESPERA settle cycles and classifies it.
module identificador_compuerta
    import identificador_compuerta_pkg::*;
#(
    parameter int ESPERA = 2
) (
    input  logic       Reloj,
    input  logic       Reset,
    input  logic       Inicio,
    output logic [1:0] Estimulo,
    input  logic       Respuesta,
    output logic [3:0] TablaVerdad,
    output logic [2:0] Tipo,
    output logic       Ocupado,
    output logic       Listo
);

    localparam logic [7:0] ESPERA_C = 8'(ESPERA);

    estado_t    estado_q;
    logic [7:0] contador_q;
    logic [1:0] indice_q;
    logic [1:0] estimulo_q;
    logic [3:0] tabla_q;
    logic [2:0] tipo_q;
    logic [2:0] tipo_d;
    logic       ocupado_q;
    logic       listo_q;

    clasificador_tabla u_clasificador (
        .TablaVerdad (tabla_q),
        .Tipo        (tipo_d)
    );

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            estado_q   <= REPOSO;
            contador_q <= 8'd0;
            indice_q   <= 2'd0;
            estimulo_q <= 2'b00;
            tabla_q    <= 4'b0000;
            tipo_q     <= TIPO_OTRA;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (Inicio) begin
                        indice_q   <= 2'd0;
                        estimulo_q <= 2'b00;
                        contador_q <= ESPERA_C;
                        tabla_q    <= 4'b0000;
                        listo_q    <= 1'b0;
                        ocupado_q  <= 1'b1;
                        estado_q   <= ESPERAR;
                    end
                end
                ESPERAR: begin
                    if (contador_q != 8'd0) begin
                        contador_q <= contador_q - 8'd1;
                    end else begin
                        // Respuesta is only ever sampled here, once per vector.
                        tabla_q[indice_q] <= Respuesta;
                        if (indice_q == 2'd3) begin
                            estado_q <= CLASIFICAR;
                        end else begin
                            indice_q   <= indice_q + 2'd1;
                            estimulo_q <= indice_q + 2'd1;
                            contador_q <= ESPERA_C;
                        end
                    end
                end
                CLASIFICAR: begin
                    tipo_q     <= tipo_d;
                    listo_q    <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estimulo_q <= 2'b00;
                    estado_q   <= REPOSO;
                end
                default: begin
                    estado_q   <= REPOSO;
                    ocupado_q  <= 1'b0;
                    estimulo_q <= 2'b00;
                end
            endcase
        end
    end

    assign Estimulo    = estimulo_q;
    assign TablaVerdad = tabla_q;
    assign Tipo        = tipo_q;
    assign Ocupado     = ocupado_q;
    assign Listo       = listo_q;

endmodule

// File: tb/tb_identificador_compuerta.sv
// Self-checking bench: three characterisers (ESPERA = 2, 0, 255), each with a
// run-level behavioural model compared every cycle, plus directed literal checks.
module tb_identificador_compuerta;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic       ini   [3];
    logic [3:0] tt    [3];
    bit         gl_en [3];
    logic [1:0] est   [3];
    logic [3:0] tabla [3];
    logic [2:0] tipo  [3];
    logic       ocu   [3];
    logic       listo [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Classification derived from the gate functions themselves, not from a lookup.
    function automatic logic [2:0] clase(input logic [3:0] t);
        logic [3:0] f_and, f_or, f_xor;
        for (int i = 0; i < 4; i++) begin
            f_and[i] = i[1] & i[0];
            f_or[i]  = i[1] | i[0];
            f_xor[i] = i[1] ^ i[0];
        end
        if (t == f_and)  return 3'd1;
        if (t == ~f_and) return 3'd2;
        if (t == f_or)   return 3'd3;
        if (t == ~f_or)  return 3'd4;
        if (t == f_xor)  return 3'd5;
        if (t == ~f_xor) return 3'd6;
        return 3'd0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int E = (g == 0) ? 2 : (g == 1) ? 0 : 255;
        localparam int P = E + 1;

        logic       resp;
        logic       glo = 1'b0;
        bit         samp;
        bit         m_valid = 1'b0;
        bit         m_busy  = 1'b0;
        bit         m_listo = 1'b0;
        int         m_n     = 0;
        logic [3:0] m_tabla = 4'b0000;
        logic [2:0] m_tipo  = 3'd0;
        logic [1:0] exp_est;

        assign resp = tt[g][est[g]] & ~glo;

        identificador_compuerta #(.ESPERA(E)) dut (
            .Reloj       (clk),
            .Reset       (rst[g]),
            .Inicio      (ini[g]),
            .Estimulo    (est[g]),
            .Respuesta   (resp),
            .TablaVerdad (tabla[g]),
            .Tipo        (tipo[g]),
            .Ocupado     (ocu[g]),
            .Listo       (listo[g])
        );

        // Run model: m_n counts edges since the accepting edge; vector i is
        // sampled on edge (i+1)*P and the result is published on edge 4*P+1.
        always @(posedge clk) begin
            if (rst[g]) begin
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_listo = 1'b0;
                m_n     = 0;
                m_tabla = 4'b0000;
                m_tipo  = 3'd0;
            end else if (!m_busy) begin
                if (ini[g]) begin
                    m_busy  = 1'b1;
                    m_n     = 0;
                    m_tabla = 4'b0000;
                    m_listo = 1'b0;
                end
            end else begin
                m_n++;
                if (m_n <= 4 * P && m_n % P == 0) m_tabla[2'(m_n / P - 1)] = resp;
                if (m_n == 4 * P + 1) begin
                    m_busy  = 1'b0;
                    m_listo = 1'b1;
                    m_tipo  = clase(m_tabla);
                end
            end
        end

        // Glitch the gate output low only when the coming edge does not sample it.
        always @(negedge clk) begin
            samp = m_busy && (m_n + 1) <= 4 * P && ((m_n + 1) % P) == 0;
            glo  = gl_en[g] && !samp && ($urandom_range(0, 1) == 1);
        end

        always @(negedge clk) begin
            if (m_valid) begin
                exp_est = m_busy ? ((m_n / P > 3) ? 2'd3 : 2'(m_n / P)) : 2'd0;
                check($sformatf("estimulo[%0d]", g), 32'(est[g]), 32'(exp_est));
                check($sformatf("tabla[%0d]", g), 32'(tabla[g]), 32'(m_tabla));
                check($sformatf("tipo[%0d]", g), 32'(tipo[g]), 32'(m_tipo));
                check($sformatf("ocupado[%0d]", g), 32'(ocu[g]), 32'(m_busy));
                check($sformatf("listo[%0d]", g), 32'(listo[g]), 32'(m_listo));
            end
        end
    end

    // Edges from acceptance until Listo is seen; returns bound+1 on timeout.
    task automatic wait_listo(input int g, input int bound, input bit repulse, output int k);
        for (k = 1; k <= bound; k++) begin
            if (repulse) ini[g] = (k == 5);
            @(posedge clk); #1;
            if (listo[g]) break;
        end
    endtask

    task automatic run_gate(input int g, input logic [3:0] gate, input bit hold, input bit repulse,
                            input int lat, input logic [3:0] exp_tt, input logic [2:0] exp_tipo);
        int k;
        tt[g] = gate;
        @(negedge clk);
        ini[g] = 1'b1;
        @(posedge clk); #1;
        if (!hold) ini[g] = 1'b0;
        wait_listo(g, lat + 10, repulse, k);
        check($sformatf("latencia[%0d]", g), 32'(k), 32'(lat));
        check($sformatf("tabla_lit[%0d]", g), 32'(tabla[g]), 32'(exp_tt));
        check($sformatf("tipo_lit[%0d]", g), 32'(tipo[g]), 32'(exp_tipo));
    endtask

    initial begin
        int k;
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; ini[g] = 1'b0; tt[g] = 4'b0000; gl_en[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_est[%0d]", g), 32'(est[g]), 32'd0);
            check($sformatf("rst_tabla[%0d]", g), 32'(tabla[g]), 32'd0);
            check($sformatf("rst_flags[%0d]", g), 32'({tipo[g], ocu[g], listo[g]}), 32'd0);
            rst[g] = 1'b0;
        end

        run_gate(0, 4'b1000, 1'b0, 1'b0, 13, 4'b1000, 3'b001);   // AND, ESPERA=2
        run_gate(1, 4'b0110, 1'b0, 1'b0, 5, 4'b0110, 3'b101);    // XOR, ESPERA=0

        gl_en[0] = 1'b1;                                          // tied high + glitches
        run_gate(0, 4'b1111, 1'b0, 1'b0, 13, 4'b1111, 3'b000);
        gl_en[0] = 1'b0;

        run_gate(0, 4'b1000, 1'b0, 1'b1, 13, 4'b1000, 3'b001);   // Inicio re-pulsed mid-run

        run_gate(0, 4'b0111, 1'b1, 1'b0, 13, 4'b0111, 3'b010);   // Inicio held high
        @(posedge clk); #1;
        check("hold_listo", 32'(listo[0]), 32'd0);
        check("hold_ocupado", 32'(ocu[0]), 32'd1);
        check("hold_tabla", 32'(tabla[0]), 32'd0);
        ini[0] = 1'b0;
        wait_listo(0, 23, 1'b0, k);
        check("hold_latencia", 32'(k), 32'd13);
        check("hold_tabla2", 32'(tabla[0]), 32'(4'b0111));

        tt[0] = 4'b1000;                                          // reset on 6th cycle of a run
        @(negedge clk);
        ini[0] = 1'b1;
        @(posedge clk); #1;
        ini[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_est", 32'(est[0]), 32'd0);
        check("rst_mid_tabla", 32'(tabla[0]), 32'd0);
        check("rst_mid_flags", 32'({tipo[0], ocu[0], listo[0]}), 32'd0);
        rst[0] = 1'b0;
        run_gate(0, 4'b1110, 1'b0, 1'b0, 13, 4'b1110, 3'b011);   // OR after reset

        run_gate(2, 4'b0001, 1'b0, 1'b0, 1025, 4'b0001, 3'b100); // NOR, ESPERA=255

        for (int c = 0; c < 400; c++) begin                        // randomized phase
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                ini[g]   = ($urandom_range(0, 2) == 0);
                if (ini[g]) tt[g] = 4'($urandom);
                rst[g]   = ($urandom_range(0, 40) == 0);
                gl_en[g] = ($urandom_range(0, 1) == 1);
            end
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            ini[g] = 1'b0; rst[g] = 1'b0; gl_en[g] = 1'b0;
        end
        repeat (30) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/identificador_compuerta.md
Name: identificador_compuerta

Overview:
Sequential characteriser for any 2-input combinational gate in the lab library. It drives the gate's 2-bit input through all four combinations and samples the 1-bit output after a settle delay. It then builds the 4-entry truth table and classifies the gate (AND, NAND, OR, NOR, XOR, XNOR, other). It is the driving/reading end of the Entrada[1:0]/Salida gate interface and is used on the board and in benches to check structural gate builds.

Parameters:
ESPERA, 2, settle cycles between driving Estimulo and sampling Respuesta; legal range 0..255.

Ports:
Reloj  input  1  single system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Inicio  input  1  start request; acted on only in REPOSO.
Estimulo  output  2  registered drive to the gate under test; bit 1 is MSB of the combination index.
Respuesta  input  1  gate-under-test output.
TablaVerdad  output  4  bit i = Respuesta captured for Estimulo == i.
Tipo  output  3  classification code, valid while Listo = 1.
Ocupado  output  1  high while a characterisation is running.
Listo  output  1  high from completion until the next accepted Inicio or Reset.

Behaviour:
- Reset (sampled at a rising edge while high, including mid-run):
  - State REPOSO; Estimulo = 00; TablaVerdad = 0000; Tipo = 000.
  - Ocupado = 0; Listo = 0; index and counter = 0.
  - Reset has priority over every other event.
- States: REPOSO, ESPERAR, CLASIFICAR.
- REPOSO:
  - Ocupado = 0. Inicio = 1 at an edge means:
    - index = 0; Estimulo = 00; counter = ESPERA.
    - TablaVerdad = 0000; Listo = 0; Ocupado = 1.
    - Next state ESPERAR.
  - Inicio = 0: all outputs hold.
- ESPERAR, with counter != 0 at an edge: counter decrements.
- ESPERAR, with counter == 0 at an edge:
  - TablaVerdad[index] = Respuesta.
  - If index == 3: next state CLASIFICAR.
  - Otherwise: index increments; Estimulo = index+1; counter = ESPERA.
  - Respuesta is never sampled at any other time.
- CLASIFICAR, in one cycle:
  - Tipo = decode(TablaVerdad); Listo = 1; Ocupado = 0; Estimulo = 00.
  - Next state REPOSO.
- Latency: each vector occupies ESPERA+1 cycles. Listo rises 4*(ESPERA+1)+1 edges after the edge that accepted Inicio; for ESPERA = 2 that is 13.
- ESPERA = 0: one cycle per vector. The gate output must then settle within the same cycle as the registered Estimulo.
- Inicio while Ocupado = 1 is ignored; there is no restart mid-run.
- Inicio held high continuously: a new run starts on the first edge after returning to REPOSO. Listo is then high for exactly one cycle.
- Tipo decode (TablaVerdad[3:0]):
  - 1000 -> 001 AND
  - 0111 -> 010 NAND
  - 1110 -> 011 OR
  - 0001 -> 100 NOR
  - 0110 -> 101 XOR
  - 1001 -> 110 XNOR
  - anything else -> 000 OTRA
- Widths:
  - Counter width 8 bits, sufficient for the ESPERA maximum of 255.
  - Index is 2 bits; it does not wrap because CLASIFICAR is entered at index 3.
- Estimulo, TablaVerdad, Tipo, Ocupado and Listo are all registered; no combinational path from input to output.

Decomposition:
- Shared constants file:
  - Tipo codes: TIPO_OTRA, TIPO_AND, TIPO_NAND, TIPO_OR, TIPO_NOR, TIPO_XOR, TIPO_XNOR.
  - State encodings: REPOSO = 2'd0, ESPERAR = 2'd1, CLASIFICAR = 2'd2; 2'd3 is unreachable and recovers to REPOSO.
- One sub-module, clasificador_tabla: combinational, TablaVerdad[3:0] in, Tipo[2:0] out. It is reused by other lab checkers. The top module registers its output in CLASIFICAR.

Test Plan:
- Gate under test is the NAND-built AND; ESPERA = 2; pulse Inicio -> Estimulo steps 00, 01, 10, 11, each held 3 cycles; Listo rises 13 edges after acceptance; TablaVerdad = 1000; Tipo = 001.
- Gate under test is XOR; ESPERA = 0; pulse Inicio -> TablaVerdad = 0110, Tipo = 101, Listo rises 5 edges after acceptance.
- Respuesta tied to 1 -> TablaVerdad = 1111, Tipo = 000. Respuesta glitched low only during non-sampling cycles -> result unchanged.
- Inicio re-pulsed during ESPERAR -> ignored; run completes with the original timing. Inicio held high through completion -> Listo high for exactly 1 cycle, and a new run starts with TablaVerdad cleared.
- Reset asserted on the 6th cycle of a run -> next edge: Estimulo = 00, Ocupado = 0, Listo = 0, TablaVerdad = 0000, Tipo = 000. A following Inicio runs a full, correct characterisation.
- NOR gate with ESPERA = 255 -> Listo after 4*256+1 = 1025 edges; TablaVerdad = 0001; Tipo = 100.
